// File: rtl/frame_capture_ctrl.sv
// Camera pixel capture into a ping-pong frame buffer: RGB565 -> grey in a 2-stage
// pipeline, BRAM write generation and bank handoff between writer and reader.
module frame_capture_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 18
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [15:0]       pixel_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              valid_in,
  input  logic              frame_done_in,
  input  logic              continuous_in,
  input  logic              capture_req_in,
  input  logic              rd_release_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic              wr_en_out,
  output logic              rd_bank_out,
  output logic              frame_ready_out,
  output logic              busy_out,
  output logic [7:0]        drop_count_out
);

  localparam int          STAGES = 2;
  localparam int          LIN_W  = ADDR_W - 1;
  localparam logic [10:0] H_LIM  = 11'(WIDTH);
  localparam logic [9:0]  V_LIM  = 10'(HEIGHT);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN1, DRAIN2, HANDOFF} state_t;

  typedef struct packed {
    logic [9:0]        sum;
    logic [ADDR_W-1:0] addr;
  } s1_t;

  state_t            state, state_nxt;
  logic              capture, handoff, busy;
  logic              wr_bank, rd_bank, frame_ready, has_frame;
  logic [7:0]        drop_cnt;
  logic [STAGES-1:0] vld_pipe;
  s1_t               s1;
  logic              vld_in;
  logic [9:0]        sum_nxt, grey_full;
  logic [LIN_W-1:0]  lin_nxt;

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state; the two drain cycles let the last pixel's write land before handoff
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (capture_req_in || continuous_in) state_nxt = WAIT_SOF;
      WAIT_SOF: if (frame_done_in) state_nxt = CAPTURE;
      CAPTURE:  if (frame_done_in) state_nxt = DRAIN1;
      DRAIN1:   state_nxt = DRAIN2;
      DRAIN2:   state_nxt = HANDOFF;
      HANDOFF:  state_nxt = continuous_in ? CAPTURE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    capture = (state == CAPTURE);
    handoff = (state == HANDOFF);
    busy    = (state == WAIT_SOF) || (state == CAPTURE);
  end

  // Stage 1: weighted channel sum and linear address
  assign vld_in  = valid_in && capture && (hcount_in < H_LIM) && (vcount_in < V_LIM);
  assign sum_nxt = {2'b0, pixel_in[15:11], 3'b0} + {2'b0, pixel_in[10:5], 2'b0}
                 + {2'b0, pixel_in[4:0], 3'b0};
  assign lin_nxt = LIN_W'(hcount_in) + LIN_W'(WIDTH) * LIN_W'(vcount_in);
  assign grey_full = (s1.sum >> 2) + (s1.sum >> 4) + (s1.sum >> 6);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe    <= '0;
      s1          <= '0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], vld_in};
      if (vld_in)
        s1 <= '{sum: sum_nxt, addr: {wr_bank, lin_nxt}};
      if (vld_pipe[0]) begin
        wr_addr_out <= s1.addr;
        wr_data_out <= grey_full[7:0];
      end
    end
  end

  assign wr_en_out = vld_pipe[STAGES-1];

  // Bank ownership; a release in the handoff cycle is honoured before the swap decision
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      has_frame   <= 1'b0;
      drop_cnt    <= '0;
    end else if (handoff) begin
      if (!frame_ready || rd_release_in) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
        has_frame   <= 1'b1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (rd_release_in) begin
      frame_ready <= 1'b0;
    end
  end

  // Read bank reads as 0 until a first frame has been handed over
  assign rd_bank_out     = rd_bank & has_frame;
  assign frame_ready_out = frame_ready;
  assign busy_out        = busy;
  assign drop_count_out  = drop_cnt;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: grey conversion, address bounds, FSM modes,
// bank ping-pong, drop counting and async reset.
module tb_frame_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pixel;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        valid, frame_done, continuous, capture_req, rd_release;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en, rd_bank, frame_ready, busy;
  logic [7:0]  drop_count;

  int n_chk  = 0;
  int n_fail = 0;
  int b0_cnt = 0;
  int b1_cnt = 0;
  int snap;

  frame_capture_ctrl #(.WIDTH(320), .HEIGHT(240), .ADDR_W(18)) dut (
    .clk_in(clk), .rst_in(rst_n), .pixel_in(pixel), .hcount_in(hcount),
    .vcount_in(vcount), .valid_in(valid), .frame_done_in(frame_done),
    .continuous_in(continuous), .capture_req_in(capture_req),
    .rd_release_in(rd_release), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .wr_en_out(wr_en), .rd_bank_out(rd_bank), .frame_ready_out(frame_ready),
    .busy_out(busy), .drop_count_out(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_addr[17]) b1_cnt++;
      else             b0_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
  endtask

  task automatic send_px(input logic [15:0] p, input int h, input int v);
    pixel  = p;
    hcount = 11'(h);
    vcount = 10'(v);
    valid  = 1'b1;
    tick(1);
    valid  = 1'b0;
  endtask

  // Pixel in, then check the write two cycles later
  task automatic px_check(input string tag, input logic [15:0] p, input int h, input int v,
                          input logic en, input logic [7:0] data, input logic [17:0] addr);
    send_px(p, h, v);
    tick(1);
    chk({tag, "_en"}, 32'(wr_en), 32'(en));
    if (en) begin
      chk({tag, "_data"}, 32'(wr_data), 32'(data));
      chk({tag, "_addr"}, 32'(wr_addr), 32'(addr));
    end
  endtask

  initial begin
    rst_n = 1'b0; pixel = '0; hcount = '0; vcount = '0; valid = 1'b0;
    frame_done = 1'b0; continuous = 1'b0; capture_req = 1'b0; rd_release = 1'b0;
    tick(2);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_ready", 32'(frame_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst_n = 1'b1;
    tick(1);

    // IDLE and WAIT_SOF never write
    snap = b0_cnt + b1_cnt;
    px_check("idle_px", 16'hFFFF, 0, 0, 1'b0, 8'd0, 18'd0);
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    chk("wait_sof_busy", 32'(busy), 1);
    px_check("wait_sof_px", 16'hFFFF, 0, 0, 1'b0, 8'd0, 18'd0);
    chk("no_write_pre_capture", 32'(b0_cnt + b1_cnt - snap), 0);
    pulse_fd();
    chk("capture_busy", 32'(busy), 1);

    // sum 748 -> 187+46+11
    px_check("white", 16'hFFFF, 0, 0, 1'b1, 8'd244, 18'd0);
    tick(1);
    chk("white_en_single", 32'(wr_en), 0);
    px_check("red", 16'hF800, 3, 1, 1'b1, 8'd80, 18'd323);
    px_check("green", 16'h07E0, 4, 1, 1'b1, 8'd81, 18'd324);
    px_check("mid", 16'h8410, 5, 2, 1'b1, 8'd126, 18'd645);
    px_check("black", 16'h0000, 6, 2, 1'b1, 8'd0, 18'd646);
    px_check("last_px", 16'h001F, 319, 239, 1'b1, 8'd80, 18'd76799);
    px_check("h_oob", 16'hFFFF, 320, 0, 1'b0, 8'd0, 18'd0);
    px_check("v_oob", 16'hFFFF, 0, 240, 1'b0, 8'd0, 18'd0);

    // Single-shot end of frame
    pulse_fd();
    tick(3);
    chk("ss_rd_bank", 32'(rd_bank), 0);
    chk("ss_ready", 32'(frame_ready), 1);
    chk("ss_busy", 32'(busy), 0);
    chk("ss_drop", 32'(drop_count), 0);
    px_check("ss_after_px", 16'hFFFF, 1, 1, 1'b0, 8'd0, 18'd0);
    rd_release = 1'b1; tick(1); rd_release = 1'b0;
    chk("release_ready", 32'(frame_ready), 0);
    chk("release_rd_bank", 32'(rd_bank), 0);

    // Async reset mid-capture
    capture_req = 1'b1; tick(1); capture_req = 1'b0;
    pulse_fd();
    chk("pre_rst_busy", 32'(busy), 1);
    send_px(16'hFFFF, 7, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_wr_en", 32'(wr_en), 0);
    tick(2);
    chk("rst_hold_wr_en", 32'(wr_en), 0);
    rst_n = 1'b1;
    tick(1);
    px_check("post_rst_px", 16'hFFFF, 8, 0, 1'b0, 8'd0, 18'd0);
    chk("post_rst_busy", 32'(busy), 0);

    // Continuous, no release: one swap then drops
    continuous = 1'b1;
    tick(1);
    pulse_fd();
    px_check("cont_f1", 16'hFFFF, 1, 0, 1'b1, 8'd244, 18'd1);
    pulse_fd();
    tick(3);
    chk("cont_f1_rd_bank", 32'(rd_bank), 0);
    chk("cont_f1_ready", 32'(frame_ready), 1);
    chk("cont_f1_drop", 32'(drop_count), 0);
    snap = b0_cnt;
    px_check("cont_f2", 16'hFFFF, 2, 0, 1'b1, 8'd244, 18'h20002);
    pulse_fd();
    pulse_fd();
    tick(2);
    chk("cont_f2_drop", 32'(drop_count), 1);
    px_check("cont_f3", 16'hF800, 3, 0, 1'b1, 8'd80, 18'h20003);
    pulse_fd();
    tick(3);
    chk("cont_f3_drop", 32'(drop_count), 2);
    chk("cont_f3_ready", 32'(frame_ready), 1);
    chk("cont_f3_rd_bank", 32'(rd_bank), 0);
    chk("cont_bank0_untouched", 32'(b0_cnt - snap), 0);

    // Release coincident with handoff
    pulse_fd();
    tick(2);
    rd_release = 1'b1; tick(1); rd_release = 1'b0;
    chk("coinc_ready", 32'(frame_ready), 1);
    chk("coinc_rd_bank", 32'(rd_bank), 1);
    chk("coinc_drop", 32'(drop_count), 2);
    px_check("coinc_px", 16'h8410, 5, 2, 1'b1, 8'd126, 18'd645);

    // Continuous dropped mid-capture: finish frame then IDLE
    continuous = 1'b0;
    pulse_fd();
    tick(3);
    chk("cont_off_drop", 32'(drop_count), 3);
    chk("cont_off_busy", 32'(busy), 0);
    chk("cont_off_rd_bank", 32'(rd_bank), 1);

    // Drop counter saturates
    continuous = 1'b1;
    tick(1);
    pulse_fd();
    repeat (260) begin
      pulse_fd();
      tick(3);
    end
    chk("drop_saturate", 32'(drop_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
